// File: rtl/mii_pkg.sv
// Shared constants and state encoding for the MII receive frame controller.
package mii_pkg;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        DROP
    } state_e;

endpackage

// File: rtl/mii_rx_frame_ctrl_if.sv
// Byte-strobe input and framed-output bundle of the MII receive frame controller.
interface mii_rx_frame_ctrl_if #(
    parameter int LEN_W = 11
);
    logic             in_rdy;
    logic [7:0]       in_q;
    logic             out_valid;
    logic [7:0]       out_data;
    logic             out_sof;
    logic             out_eof;
    logic             out_err;
    logic             frame_done;
    logic [LEN_W-1:0] frame_len;
    logic [15:0]      frames_ok;
    logic [15:0]      frames_err;

    modport master (
        output in_rdy, in_q,
        input  out_valid, out_data, out_sof, out_eof, out_err,
        input  frame_done, frame_len, frames_ok, frames_err
    );

    modport slave (
        input  in_rdy, in_q,
        output out_valid, out_data, out_sof, out_eof, out_err,
        output frame_done, frame_len, frames_ok, frames_err
    );
endinterface

// File: rtl/mii_gap_timer.sv
// Counts silent cycles since the last byte strobe; gap marks the GAP_CYCLES-th one.
module mii_gap_timer #(
    parameter int GAP_CYCLES = 4
) (
    input  logic mii_clk,
    input  logic reset,
    input  logic in_rdy,
    output logic gap
);
    localparam int CW = $clog2(GAP_CYCLES + 1);
    localparam logic [CW-1:0] GAP_MAX = CW'(GAP_CYCLES);

    logic [CW-1:0] gap_cnt_q, gap_cnt_d;

    always_comb begin
        gap_cnt_d = gap_cnt_q;
        if (in_rdy) begin
            gap_cnt_d = '0;
        end else if (gap_cnt_q != GAP_MAX) begin
            gap_cnt_d = gap_cnt_q + 1'b1;
        end
    end

    // Start saturated so the line looks already silent out of reset.
    always_ff @(posedge mii_clk or posedge reset) begin
        if (reset) begin
            gap_cnt_q <= GAP_MAX;
        end else begin
            gap_cnt_q <= gap_cnt_d;
        end
    end

    assign gap = !in_rdy && (gap_cnt_q == GAP_MAX - 1'b1);
endmodule

// File: rtl/mii_rx_frame_ctrl.sv
// Strips preamble/SFD, delimits frames by silence and emits bytes with sof/eof/err
// framing plus length and good/bad frame counters.
module mii_rx_frame_ctrl
    import mii_pkg::*;
#(
    parameter int GAP_CYCLES   = 4,
    parameter int MIN_PREAMBLE = 2,
    parameter int MIN_LEN      = 64,
    parameter int MAX_LEN      = 1518,
    parameter int LEN_W        = 11
) (
    input  logic                mii_clk,
    input  logic                reset,
    mii_rx_frame_ctrl_if.slave  bus
);
    localparam logic [2:0]       MIN_PRE = 3'(MIN_PREAMBLE);
    localparam logic [LEN_W-1:0] MIN_L   = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_LEN);

    logic gap;

    mii_gap_timer #(.GAP_CYCLES(GAP_CYCLES)) u_gap_timer (
        .mii_clk (mii_clk),
        .reset   (reset),
        .in_rdy  (bus.in_rdy),
        .gap     (gap)
    );

    state_e           state_q, state_d;
    logic [2:0]       pre_cnt_q, pre_cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             have_byte_q, have_byte_d;
    logic             first_q, first_d;
    logic [7:0]       hold_q, hold_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_sof_q, out_sof_d;
    logic             out_eof_q, out_eof_d;
    logic             out_err_q, out_err_d;
    logic             frame_done_q, frame_done_d;
    logic [LEN_W-1:0] frame_len_q, frame_len_d;
    logic [15:0]      frames_ok_q, frames_ok_d;
    logic [15:0]      frames_err_q, frames_err_d;
    logic             len_err;

    assign len_err = (len_q < MIN_L) || (len_q > MAX_L);

    always_comb begin
        state_d      = state_q;
        pre_cnt_d    = pre_cnt_q;
        len_d        = len_q;
        have_byte_d  = have_byte_q;
        first_d      = first_q;
        hold_d       = hold_q;
        out_valid_d  = 1'b0;
        out_data_d   = out_data_q;
        out_sof_d    = 1'b0;
        out_eof_d    = 1'b0;
        out_err_d    = 1'b0;
        frame_done_d = 1'b0;
        frame_len_d  = frame_len_q;
        frames_ok_d  = frames_ok_q;
        frames_err_d = frames_err_q;

        case (state_q)
            IDLE: begin
                if (bus.in_rdy) begin
                    if (bus.in_q == PREAMBLE_BYTE) begin
                        state_d   = PREAMBLE;
                        pre_cnt_d = 3'd1;
                    end else begin
                        state_d = DROP;
                    end
                end
            end
            PREAMBLE: begin
                if (bus.in_rdy) begin
                    if (bus.in_q == PREAMBLE_BYTE) begin
                        if (pre_cnt_q != 3'd7) pre_cnt_d = pre_cnt_q + 3'd1;
                    end else if (bus.in_q == SFD_BYTE && pre_cnt_q >= MIN_PRE) begin
                        state_d     = DATA;
                        len_d       = '0;
                        have_byte_d = 1'b0;
                        first_d     = 1'b1;
                    end else begin
                        state_d = DROP;
                    end
                end else if (gap) begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                // One byte is always held back so the final one can carry eof.
                if (bus.in_rdy) begin
                    if (have_byte_q) begin
                        out_valid_d = 1'b1;
                        out_data_d  = hold_q;
                        out_sof_d   = first_q;
                        first_d     = 1'b0;
                    end
                    hold_d      = bus.in_q;
                    have_byte_d = 1'b1;
                    if (len_q != '1) len_d = len_q + 1'b1;
                end else if (gap) begin
                    state_d = IDLE;
                    if (have_byte_q) begin
                        out_valid_d  = 1'b1;
                        out_data_d   = hold_q;
                        out_sof_d    = first_q;
                        out_eof_d    = 1'b1;
                        out_err_d    = len_err;
                        frame_done_d = 1'b1;
                        frame_len_d  = len_q;
                        if (len_err) frames_err_d = frames_err_q + 16'd1;
                        else         frames_ok_d  = frames_ok_q + 16'd1;
                    end
                end
            end
            DROP: begin
                if (gap) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge mii_clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pre_cnt_q    <= '0;
            len_q        <= '0;
            have_byte_q  <= 1'b0;
            first_q      <= 1'b0;
            hold_q       <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_sof_q    <= 1'b0;
            out_eof_q    <= 1'b0;
            out_err_q    <= 1'b0;
            frame_done_q <= 1'b0;
            frame_len_q  <= '0;
            frames_ok_q  <= '0;
            frames_err_q <= '0;
        end else begin
            state_q      <= state_d;
            pre_cnt_q    <= pre_cnt_d;
            len_q        <= len_d;
            have_byte_q  <= have_byte_d;
            first_q      <= first_d;
            hold_q       <= hold_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_sof_q    <= out_sof_d;
            out_eof_q    <= out_eof_d;
            out_err_q    <= out_err_d;
            frame_done_q <= frame_done_d;
            frame_len_q  <= frame_len_d;
            frames_ok_q  <= frames_ok_d;
            frames_err_q <= frames_err_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_sof    = out_sof_q;
    assign bus.out_eof    = out_eof_q;
    assign bus.out_err    = out_err_q;
    assign bus.frame_done = frame_done_q;
    assign bus.frame_len  = frame_len_q;
    assign bus.frames_ok  = frames_ok_q;
    assign bus.frames_err = frames_err_q;
endmodule

// File: tb/tb_mii_rx_frame_ctrl.sv
// Scoreboard bench for mii_rx_frame_ctrl: expected beats/frames are queued as stimulus is driven.
module tb_mii_rx_frame_ctrl;
    import mii_pkg::*;

    localparam int GAP   = 4;
    localparam int LEN_W = 11;

    typedef struct packed {
        logic [7:0] d;
        logic       sof;
        logic       eof;
        logic       err;
    } beat_t;

    typedef struct packed {
        logic [LEN_W-1:0] len;
        logic             err;
    } frm_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mii_rx_frame_ctrl_if #(.LEN_W(LEN_W)) ifc ();

    mii_rx_frame_ctrl #(
        .GAP_CYCLES   (GAP),
        .MIN_PREAMBLE (2),
        .MIN_LEN      (64),
        .MAX_LEN      (1518),
        .LEN_W        (LEN_W)
    ) dut (
        .mii_clk (clk),
        .reset   (rst),
        .bus     (ifc.slave)
    );

    beat_t exp_q[$];
    frm_t  frm_q[$];
    beat_t b_exp;
    frm_t  f_exp;
    int checks  = 0;
    int errors  = 0;
    int exp_ok  = 0;
    int exp_err = 0;
    int cyc     = 0;
    int rdy_cyc = 0;
    int eof_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: every beat and every frame_done is matched against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (ifc.out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat_unexpected got data=%h sof=%b eof=%b required no output",
                             ifc.out_data, ifc.out_sof, ifc.out_eof);
                end else begin
                    b_exp = exp_q.pop_front();
                    if ({ifc.out_data, ifc.out_sof, ifc.out_eof, ifc.out_err} !== b_exp) begin
                        errors++;
                        $display("FAIL beat got d=%h sof=%b eof=%b err=%b required d=%h sof=%b eof=%b err=%b",
                                 ifc.out_data, ifc.out_sof, ifc.out_eof, ifc.out_err,
                                 b_exp.d, b_exp.sof, b_exp.eof, b_exp.err);
                    end
                end
                if (ifc.out_eof) eof_cyc = cyc;
            end
            if (ifc.frame_done || (ifc.out_valid && ifc.out_eof)) begin
                checks++;
                if (ifc.frame_done !== (ifc.out_valid && ifc.out_eof)) begin
                    errors++;
                    $display("FAIL frame_done_align got frame_done=%b required %b",
                             ifc.frame_done, ifc.out_valid && ifc.out_eof);
                end else if (frm_q.size() == 0) begin
                    errors++;
                    $display("FAIL frame_unexpected got len=%0d required no frame", ifc.frame_len);
                end else begin
                    f_exp = frm_q.pop_front();
                    if (ifc.frame_len !== f_exp.len) begin
                        errors++;
                        $display("FAIL frame_len got %0d required %0d", ifc.frame_len, f_exp.len);
                    end
                    $display("frame done len=%0d err=%b ok=%0d bad=%0d",
                             ifc.frame_len, ifc.out_err, ifc.frames_ok, ifc.frames_err);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        ifc.in_rdy = 1'b1;
        ifc.in_q   = b;
        rdy_cyc    = cyc;
        @(posedge clk); #1;
        ifc.in_rdy = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Queues the expected beats/frame for the model, then drives the bytes.
    task automatic send_frame(input int npre, input logic [7:0] sfd, input int n, input bit abort);
        bit accepted;
        int flen;
        logic ferr;
        beat_t bt;
        frm_t  fr;
        accepted = (npre >= 2) && (sfd == 8'hD5);
        flen = (n > 2047) ? 2047 : n;
        ferr = (n < 64) || (n > 1518);
        if (accepted && n > 0) begin
            for (int i = 0; i < n - 1; i++) begin
                bt = '{d: 8'(i), sof: (i == 0), eof: 1'b0, err: 1'b0};
                exp_q.push_back(bt);
            end
            if (!abort) begin
                bt = '{d: 8'(n - 1), sof: (n == 1), eof: 1'b1, err: ferr};
                exp_q.push_back(bt);
                fr = '{len: LEN_W'(flen), err: ferr};
                frm_q.push_back(fr);
                if (ferr) exp_err++;
                else      exp_ok++;
            end
        end
        for (int i = 0; i < npre; i++) send_byte(8'h55);
        send_byte(sfd);
        for (int i = 0; i < n; i++) send_byte(8'(i));
        if (!abort) idle(GAP + 8);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifc.in_rdy = 1'b0;
        ifc.in_q   = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ifc.out_valid, ifc.out_data, ifc.out_sof, ifc.out_eof, ifc.out_err, ifc.frame_done,
             ifc.frame_len, ifc.frames_ok, ifc.frames_err} !== 56'd0) begin
            errors++;
            $display("FAIL reset_outputs got valid=%b data=%h len=%0d ok=%0d bad=%0d required all 0",
                     ifc.out_valid, ifc.out_data, ifc.frame_len, ifc.frames_ok, ifc.frames_err);
        end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_good_frame();
        send_frame(7, 8'hD5, 64, 1'b0);
        checks++;
        if (exp_q.size() != 0 || frm_q.size() != 0) begin
            errors++;
            $display("FAIL good_drain got pending=%0d required 0", exp_q.size() + frm_q.size());
        end
        checks++;
        if (ifc.frames_ok !== 16'(exp_ok) || ifc.frames_err !== 16'(exp_err)) begin
            errors++;
            $display("FAIL good_counters got ok=%0d bad=%0d required ok=%0d bad=%0d",
                     ifc.frames_ok, ifc.frames_err, exp_ok, exp_err);
        end
        checks++;
        if (eof_cyc - rdy_cyc != GAP + 1) begin
            errors++;
            $display("FAIL eof_latency got %0d required %0d", eof_cyc - rdy_cyc, GAP + 1);
        end
        checks++;
        if (ifc.frame_len !== 11'd64) begin
            errors++;
            $display("FAIL good_len_hold got %0d required 64", ifc.frame_len);
        end
    endtask

    task automatic test_short_frame();
        send_frame(7, 8'hD5, 10, 1'b0);
        checks++;
        if (ifc.frames_err !== 16'(exp_err) || ifc.frame_len !== 11'd10 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL short_frame got bad=%0d len=%0d pending=%0d required bad=%0d len=10 pending=0",
                     ifc.frames_err, ifc.frame_len, exp_q.size(), exp_err);
        end
    endtask

    task automatic test_bad_sfd();
        send_frame(7, 8'hAA, 20, 1'b0);
        checks++;
        if (ifc.frames_ok !== 16'(exp_ok) || ifc.frames_err !== 16'(exp_err)) begin
            errors++;
            $display("FAIL bad_sfd_counters got ok=%0d bad=%0d required ok=%0d bad=%0d",
                     ifc.frames_ok, ifc.frames_err, exp_ok, exp_err);
        end
        send_frame(7, 8'hD5, 64, 1'b0);
        checks++;
        if (ifc.frames_ok !== 16'(exp_ok) || exp_q.size() != 0) begin
            errors++;
            $display("FAIL after_bad_sfd got ok=%0d pending=%0d required ok=%0d pending=0",
                     ifc.frames_ok, exp_q.size(), exp_ok);
        end
    endtask

    task automatic test_short_preamble();
        send_frame(1, 8'hD5, 64, 1'b0);
        checks++;
        if (ifc.frames_ok !== 16'(exp_ok) || ifc.frames_err !== 16'(exp_err)) begin
            errors++;
            $display("FAIL short_pre_dropped got ok=%0d bad=%0d required ok=%0d bad=%0d",
                     ifc.frames_ok, ifc.frames_err, exp_ok, exp_err);
        end
        send_frame(2, 8'hD5, 64, 1'b0);
        checks++;
        if (ifc.frames_ok !== 16'(exp_ok) || exp_q.size() != 0) begin
            errors++;
            $display("FAIL min_pre_accepted got ok=%0d pending=%0d required ok=%0d pending=0",
                     ifc.frames_ok, exp_q.size(), exp_ok);
        end
    endtask

    task automatic test_one_byte_and_sfd_only();
        send_frame(7, 8'hD5, 1, 1'b0);
        checks++;
        if (ifc.frame_len !== 11'd1 || ifc.frames_err !== 16'(exp_err)) begin
            errors++;
            $display("FAIL one_byte got len=%0d bad=%0d required len=1 bad=%0d",
                     ifc.frame_len, ifc.frames_err, exp_err);
        end
        send_frame(7, 8'hD5, 0, 1'b0);
        checks++;
        if (ifc.frame_len !== 11'd1 || ifc.frames_ok !== 16'(exp_ok) || ifc.frames_err !== 16'(exp_err)) begin
            errors++;
            $display("FAIL sfd_only got len=%0d ok=%0d bad=%0d required len=1 ok=%0d bad=%0d",
                     ifc.frame_len, ifc.frames_ok, ifc.frames_err, exp_ok, exp_err);
        end
    endtask

    task automatic test_long_frame();
        send_frame(7, 8'hD5, 1520, 1'b0);
        checks++;
        if (ifc.frame_len !== 11'd1520 || ifc.frames_err !== 16'(exp_err) || exp_q.size() != 0) begin
            errors++;
            $display("FAIL long_frame got len=%0d bad=%0d pending=%0d required len=1520 bad=%0d pending=0",
                     ifc.frame_len, ifc.frames_err, exp_q.size(), exp_err);
        end
    endtask

    task automatic test_mid_frame_reset();
        send_frame(7, 8'hD5, 20, 1'b1);
        rst = 1'b1;
        #1;
        checks++;
        if ({ifc.out_valid, ifc.out_data, ifc.out_sof, ifc.out_eof, ifc.out_err, ifc.frame_done,
             ifc.frame_len, ifc.frames_ok, ifc.frames_err} !== 56'd0) begin
            errors++;
            $display("FAIL midreset_outputs got valid=%b eof=%b len=%0d ok=%0d required all 0",
                     ifc.out_valid, ifc.out_eof, ifc.frame_len, ifc.frames_ok);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL midreset_pending got %0d required 0", exp_q.size());
        end
        exp_q.delete();
        frm_q.delete();
        exp_ok  = 0;
        exp_err = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);
        send_frame(7, 8'hD5, 64, 1'b0);
        checks++;
        if (ifc.frames_ok !== 16'd1 || ifc.frames_err !== 16'd0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL after_reset got ok=%0d bad=%0d pending=%0d required ok=1 bad=0 pending=0",
                     ifc.frames_ok, ifc.frames_err, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_short_frame();
        test_bad_sfd();
        test_short_preamble();
        test_one_byte_and_sfd_only();
        test_long_frame();
        test_mid_frame_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
